mem_responder: RTL and testbench

Multi-cycle word memory that answers the read/write requests issued by the multi-cycle MIPS controller/datapath (MemRead, MemWrite, with the address already selected by IorD). It sits on the memory side of that interface and serves instruction fetches and LW/SW data accesses from one unified array. A configurable wait-state count models slow memory, and a one-cycle `ready` pulse lets a stall-aware controller hold its state until the access completes.

---
 rtl/mem_responder.sv | 147 ++++++++++++++
 tb/tb_mem_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Multi-cycle word memory answering MemRead/MemWrite with LATENCY wait states.
// Optional address checking is enabled by defining MEMRESP_ERR_CHECK_EN.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Operation being resolved: live inputs when RESP follows acceptance directly
    logic          op_rd, op_wr, op_bad;
    logic [31:0]   op_addr, op_wdata;
    logic [AW-1:0] op_idx;
    logic          enter_resp, mem_we;

    assign op_rd    = (state_q == IDLE) ? MemRead  : rd_q;
    assign op_wr    = (state_q == IDLE) ? MemWrite : wr_q;
    assign op_addr  = (state_q == IDLE) ? addr     : addr_q;
    assign op_wdata = (state_q == IDLE) ? wdata    : wdata_q;
    assign op_idx   = op_addr[AW+1:2];

`ifdef MEMRESP_ERR_CHECK_EN
    assign op_bad = (|op_addr[1:0]) | (|op_addr[31:AW+2]);
`else
    logic addr_unused;
    assign op_bad      = 1'b0;
    assign addr_unused = ^{op_addr[31:AW+2], op_addr[1:0]};
`endif

    // Next-state, latching and response resolution
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        enter_resp = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead | MemWrite) begin
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = LAT;
                    if (LAT == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            if (op_rd & op_wr) begin
                err_d = 1'b1;
            end else if (op_bad) begin
                err_d = 1'b1;
                if (op_rd) rdata_d = '0;
            end else if (op_wr) begin
                mem_we = ~rst;
            end else begin
                rdata_d = mem_q[op_idx];
            end
        end
        ready_d = (state_d == RESP);
        busy_d  = (state_d != IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[op_idx] <= op_wdata;
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 with LATENCY=2, instance 1 with LATENCY=0.
// Transaction-level model plus directed literal checks.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mr [2] = '{1'b0, 1'b0};
    logic        mw [2] = '{1'b0, 1'b0};
    logic [31:0] ad [2] = '{32'd0, 32'd0};
    logic [31:0] wd [2] = '{32'd0, 32'd0};
    logic [31:0] rd_o [2];
    logic        rdy_o [2];
    logic        bsy_o [2];
    logic        err_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u0 (
        .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]),
        .addr(ad[0]), .wdata(wd[0]), .rdata(rd_o[0]),
        .ready(rdy_o[0]), .busy(bsy_o[0]), .err(err_o[0]));

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u1 (
        .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]),
        .addr(ad[1]), .wdata(wd[1]), .rdata(rd_o[1]),
        .ready(rdy_o[1]), .busy(bsy_o[1]), .err(err_o[1]));

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level model ----------------
    int          ec = 0;
    int          lat [2] = '{2, 0};
    bit          act [2];
    int          acc [2];
    bit          t_rd [2], t_wr [2], t_err [2];
    logic [31:0] t_ad [2], t_wd [2];
    logic [31:0] m_rdata [2];
    logic [31:0] mm [2][1024];
    bit          fin, bad;
    int          ix;

    initial begin
        for (int k = 0; k < 2; k++) begin
            act[k] = 0; m_rdata[k] = 0; t_err[k] = 0; acc[k] = 0;
        end
    end

    always @(posedge clk) begin
        ec++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                act[k]     = 0;
                m_rdata[k] = 0;
            end else begin
                fin = 0;
                if (act[k] && ec == acc[k] + lat[k] + 1) begin
                    act[k] = 0;
                    fin    = 1;
                end
                if (!act[k] && !fin && (mr[k] || mw[k])) begin
                    act[k] = 1; acc[k] = ec;
                    t_rd[k] = mr[k]; t_wr[k] = mw[k];
                    t_ad[k] = ad[k]; t_wd[k] = wd[k];
                end
                if (act[k] && ec == acc[k] + lat[k]) begin
                    ix = int'(t_ad[k] / 4) % 1024;
`ifdef MEMRESP_ERR_CHECK_EN
                    bad = (t_ad[k] % 4 != 0) || (t_ad[k] >= 4096);
`else
                    bad = 0;
`endif
                    t_err[k] = (t_rd[k] && t_wr[k]) || bad;
                    if (t_rd[k] && t_wr[k]) begin
                    end else if (bad) begin
                        if (t_rd[k]) m_rdata[k] = 0;
                    end else if (t_wr[k]) begin
                        mm[k][ix] = t_wd[k];
                    end else begin
                        m_rdata[k] = mm[k][ix];
                    end
                end
            end
        end
    end

    // Compare DUT outputs with the model every cycle
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic e_rdy;
            e_rdy = !rst && act[k] && (ec == acc[k] + lat[k]);
            chk($sformatf("m_ready%0d", k), 32'(rdy_o[k]), 32'(e_rdy));
            chk($sformatf("m_busy%0d", k), 32'(bsy_o[k]), 32'(!rst && act[k]));
            chk($sformatf("m_err%0d", k), 32'(err_o[k]), 32'(e_rdy && t_err[k]));
            chk($sformatf("m_rdata%0d", k), rd_o[k], rst ? 32'd0 : m_rdata[k]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic txn(input int k, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit chg, input logic [31:0] a2, input logic [31:0] d2,
                       output logic [31:0] q, output logic e,
                       output int lat_n, output int busy_n);
        @(negedge clk);
        mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d;
        lat_n = 0; busy_n = 0; q = 0; e = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bsy_o[k]) busy_n++;
            if (chg && i == 1) begin
                ad[k] = a2; wd[k] = d2;
            end
            if (rdy_o[k]) begin
                lat_n = i; q = rd_o[k]; e = err_o[k];
                mr[k] = 0; mw[k] = 0;
                break;
            end
        end
        if (lat_n == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: no ready on instance %0d", k);
            mr[k] = 0; mw[k] = 0;
        end
        @(negedge clk);
        chk("busy_after_ready", 32'(bsy_o[k]), 32'd0);
    endtask

    task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q; logic e; int l, b;
        txn(k, 1'b0, 1'b1, a, d, 1'b0, 0, 0, q, e, l, b);
        chk("wr_err", 32'(e), 32'd0);
    endtask

    task automatic rd(input int k, input logic [31:0] a, input logic [31:0] x);
        logic [31:0] q; logic e; int l, b;
        txn(k, 1'b1, 1'b0, a, 0, 1'b0, 0, 0, q, e, l, b);
        chk("rd_data", q, x);
        chk("rd_err", 32'(e), 32'd0);
    endtask

    initial begin
        logic [31:0] q; logic e; int l, b, got, first, second;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(rdy_o[0]), 32'd0);
        chk("rst_busy", 32'(bsy_o[0]), 32'd0);
        chk("rst_err", 32'(err_o[0]), 32'd0);
        chk("rst_rdata", rd_o[0], 32'd0);
        #2 rst = 1'b0;

        txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 0, 0, q, e, l, b);
        chk("l2_ready_lat", 32'(l), 32'd3);
        chk("l2_busy_cycles", 32'(b), 32'd3);
        chk("l2_wr_err", 32'(e), 32'd0);
        rd(0, 32'h10, 32'hDEADBEEF);

        txn(1, 1'b0, 1'b1, 32'h0, 32'h8C080004, 1'b0, 0, 0, q, e, l, b);
        chk("l0_ready_lat", 32'(l), 32'd1);
        @(negedge clk);
        mr[1] = 1; ad[1] = 0; got = 0; first = 0; second = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rdy_o[1]) begin
                got++;
                chk("l0_hold_rdata", rd_o[1], 32'h8C080004);
                if (got == 1) first = i;
                else begin
                    second = i; mr[1] = 0;
                    break;
                end
            end
        end
        mr[1] = 0;
        chk("l0_first_ready", 32'(first), 32'd1);
        chk("l0_second_ready", 32'(second), 32'd3);
        @(negedge clk);

        wr(0, 32'h24, 32'h22222222);
        txn(0, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b1, 32'h24, 32'h99999999,
            q, e, l, b);
        rd(0, 32'h20, 32'h11111111);
        rd(0, 32'h24, 32'h22222222);

        wr(0, 32'h40, 32'h12345678);
        @(negedge clk);
        mw[0] = 1; ad[0] = 32'h40; wd[0] = 32'hAAAAAAAA;
        @(negedge clk);
        chk("wait_busy", 32'(bsy_o[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 32'(rdy_o[0]), 32'd0);
        chk("arst_busy", 32'(bsy_o[0]), 32'd0);
        chk("arst_rdata", rd_o[0], 32'd0);
        mw[0] = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        rd(0, 32'h40, 32'h12345678);

        wr(0, 32'h8, 32'h0BADF00D);
        rd(0, 32'h8, 32'h0BADF00D);
        txn(0, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 1'b0, 0, 0, q, e, l, b);
        chk("rw_err", 32'(e), 32'd1);
        chk("rw_rdata", q, 32'h0BADF00D);
        rd(0, 32'h8, 32'h0BADF00D);

        wr(0, 32'h4, 32'h44444444);
`ifdef MEMRESP_ERR_CHECK_EN
        txn(0, 1'b0, 1'b1, 32'h6, 32'h77, 1'b0, 0, 0, q, e, l, b);
        chk("misalign_err", 32'(e), 32'd1);
        rd(0, 32'h4, 32'h44444444);
`else
        txn(0, 1'b0, 1'b1, 32'h1006, 32'h55, 1'b0, 0, 0, q, e, l, b);
        chk("wrap_err", 32'(e), 32'd0);
        rd(0, 32'h4, 32'h55);
`endif

        for (int i = 0; i < 4; i++)
            wr(i % 2, 32'h100 + 32'(i * 4), 32'hA5000000 + 32'(i * 3));
        for (int i = 0; i < 4; i++)
            rd(i % 2, 32'h100 + 32'(i * 4), 32'hA5000000 + 32'(i * 3));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
